// File: rtl/jt51_noise_chk.sv
// ============================================================================
// Module   : jt51_noise_chk
// Brief    : Self-synchronising checker for the 17-bit XNOR noise LFSR stream
//            (taps 16/13); reports lock, bit errors, lock loss and lock-up.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jt51_noise_chk #(
    parameter int LOCK_N = 32,
    parameter int LOSS_N = 4,
    parameter int ERRW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            base,
    input  logic            din,
    input  logic            clr_err,
    output logic            locked,
    output logic            err,
    output logic            lost,
    output logic            stuck,
    output logic [ERRW-1:0] err_cnt
);

    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [7:0] c_LOCK_LAST = 8'(LOCK_N - 1);
    localparam logic [7:0] c_LOSS_LAST = 8'(LOSS_N - 1);
    localparam logic [4:0] c_FILL_LAST = 5'd16;

    logic [1:0]      state_q, state_d;
    logic [16:0]     win_q, win_d;
    logic [4:0]      fill_q, fill_d;
    logic [7:0]      run_q, run_d;
    logic            locked_q, locked_d;
    logic            err_q, err_d;
    logic            lost_q, lost_d;
    logic            stuck_q, stuck_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    logic w_pred;
    logic w_match;
    logic w_ones;

    // Prediction always comes from the window as it stood before this sample.
    assign w_pred  = ~(win_q[16] ^ win_q[13]);
    assign w_match = (din == w_pred);
    assign w_ones  = &win_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FILL;
            win_q     <= '0;
            fill_q    <= '0;
            run_q     <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            lost_q    <= 1'b0;
            stuck_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            fill_q    <= fill_d;
            run_q     <= run_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            lost_q    <= lost_d;
            stuck_q   <= stuck_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        run_d   = run_q;
        if (base) begin
            win_d = {win_q[15:0], din};
            case (state_q)
                S_FILL: begin
                    if (fill_q == c_FILL_LAST) begin
                        state_d = S_CHECK;
                        fill_d  = '0;
                        run_d   = '0;
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                S_CHECK: begin
                    // The all-ones window self-predicts forever, so it never counts.
                    if (w_match && !w_ones) begin
                        if (run_q == c_LOCK_LAST) begin
                            state_d = S_LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 8'd1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (w_match) begin
                        run_d = '0;
                    end else if (run_q == c_LOSS_LAST) begin
                        state_d = S_FILL;
                        fill_d  = '0;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_FILL;
                    fill_d  = '0;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        err_d     = base && (state_q == S_LOCKED) && !w_match;
        lost_d    = err_d && (run_q == c_LOSS_LAST);
        locked_d  = (state_d == S_LOCKED);
        stuck_d   = &win_d;
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (err_d && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign lost    = lost_q;
    assign stuck   = stuck_q;
    assign err_cnt = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_jt51_noise_chk.sv
// ============================================================================
// Module   : tb_jt51_noise_chk
// Brief    : Directed self-checking bench for jt51_noise_chk, driven by a
//            reference XNOR LFSR generator seeded 17'h0378C.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jt51_noise_chk;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        base;
    logic        din;
    logic        clr_err;
    logic        locked, err, lost, stuck;
    logic [15:0] err_cnt;
    logic        locked4, err4, lost4, stuck4;
    logic [3:0]  err_cnt4;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [16:0] gen_q;
    int          err_pulses    = 0;
    int          lost_pulses   = 0;
    int          locked_cycles = 0;

    always #5 clk = ~clk;

    jt51_noise_chk dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .base    (base),
        .din     (din),
        .clr_err (clr_err),
        .locked  (locked),
        .err     (err),
        .lost    (lost),
        .stuck   (stuck),
        .err_cnt (err_cnt)
    );

    jt51_noise_chk #(.ERRW(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .base    (base),
        .din     (din),
        .clr_err (clr_err),
        .locked  (locked4),
        .err     (err4),
        .lost    (lost4),
        .stuck   (stuck4),
        .err_cnt (err_cnt4)
    );

    always @(negedge clk) begin
        if (err)    err_pulses    <= err_pulses + 1;
        if (lost)   lost_pulses   <= lost_pulses + 1;
        if (locked) locked_cycles <= locked_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic d, input logic clr);
        base    = 1'b1;
        din     = d;
        clr_err = clr;
        @(posedge clk);
        #1;
        base    = 1'b0;
        din     = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic gen_strobe(input logic flip, input logic clr);
        logic b;
        b     = ~(gen_q[16] ^ gen_q[13]);
        gen_q = {gen_q[15:0], b};
        strobe(b ^ flip, clr);
    endtask

    task automatic run_gen(input int n, input int gap);
        repeat (n) begin
            gen_strobe(1'b0, 1'b0);
            if (gap > 1) idle(gap - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, l0, lc0;
        rst_n   = 1'b0;
        base    = 1'b0;
        din     = 1'b0;
        clr_err = 1'b0;
        gen_q   = 17'h0378C;
        idle(2);
        check("rst_flags", {28'd0, locked, err, lost, stuck}, 32'd0);
        check("rst_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;

        // Acquisition with a strobe every third clock
        run_gen(48, 3);
        check("lock_48", 32'(locked), 32'd0);
        run_gen(1, 3);
        check("lock_49", 32'(locked), 32'd1);
        e0 = err_pulses;
        run_gen(10000 - 49, 3);
        check("clean_cnt", 32'(err_cnt), 32'd0);
        check("clean_pulses", 32'(err_pulses - e0), 32'd0);
        check("clean_locked", 32'(locked), 32'd1);

        // Single flipped bit: hit directly, then again at taps 13 and 16
        l0 = lost_pulses;
        gen_strobe(1'b1, 1'b0);
        check("flip_err", 32'(err), 32'd1);
        check("flip_cnt1", 32'(err_cnt), 32'd1);
        check("flip_locked", 32'(locked), 32'd1);
        run_gen(30, 1);
        check("flip_cnt3", 32'(err_cnt), 32'd3);
        check("flip_nolost", 32'(lost_pulses - l0), 32'd0);
        check("flip_locked2", 32'(locked), 32'd1);

        // clr_err colliding with an error increment
        gen_strobe(1'b1, 1'b0);
        run_gen(13, 1);
        gen_strobe(1'b0, 1'b0);
        check("coll_cnt5", 32'(err_cnt), 32'd5);
        run_gen(2, 1);
        gen_strobe(1'b0, 1'b1);
        check("coll_err", 32'(err), 32'd1);
        check("coll_cnt0", 32'(err_cnt), 32'd0);
        check("coll_cnt0_w4", 32'(err_cnt4), 32'd0);
        run_gen(20, 1);

        // Loss of lock: 8 corrupted strobes, lock drops on the 4th
        l0 = lost_pulses;
        repeat (3) gen_strobe(1'b1, 1'b0);
        check("loss_3_locked", 32'(locked), 32'd1);
        check("loss_3_lost", 32'(lost), 32'd0);
        gen_strobe(1'b1, 1'b0);
        check("loss_4_lost", 32'(lost), 32'd1);
        check("loss_4_locked", 32'(locked), 32'd0);
        check("loss_4_cnt", 32'(err_cnt), 32'd4);
        repeat (4) gen_strobe(1'b1, 1'b0);
        check("loss_pulses", 32'(lost_pulses - l0), 32'd1);
        check("loss_cnt", 32'(err_cnt), 32'd4);
        run_gen(48, 1);
        check("relock_48", 32'(locked), 32'd0);
        run_gen(1, 1);
        check("relock_49", 32'(locked), 32'd1);

        // Saturation of the narrow counter; each flip costs exactly 3 errors
        gen_strobe(1'b0, 1'b1);
        check("sat_clr", 32'(err_cnt4), 32'd0);
        repeat (5) begin
            gen_strobe(1'b1, 1'b0);
            run_gen(19, 1);
        end
        check("sat_cnt15", 32'(err_cnt), 32'd15);
        check("sat_w4_15", 32'(err_cnt4), 32'd15);
        repeat (2) begin
            gen_strobe(1'b1, 1'b0);
            run_gen(19, 1);
        end
        check("sat_cnt21", 32'(err_cnt), 32'd21);
        check("sat_w4_hold", 32'(err_cnt4), 32'd15);
        check("sat_locked", 32'(locked), 32'd1);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_flags", {28'd0, locked, err, lost, stuck}, 32'd0);
        check("arst_cnt", 32'(err_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        idle(1);
        run_gen(48, 1);
        check("arst_relock_48", 32'(locked), 32'd0);
        run_gen(1, 1);
        check("arst_relock_49", 32'(locked), 32'd1);

        // Constant ones: XNOR lock-up pattern must never lock
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        repeat (16) strobe(1'b1, 1'b0);
        check("stuck_16", 32'(stuck), 32'd0);
        strobe(1'b1, 1'b0);
        check("stuck_17", 32'(stuck), 32'd1);
        lc0 = locked_cycles;
        repeat (983) strobe(1'b1, 1'b0);
        check("stuck_hold", 32'(stuck), 32'd1);
        check("stuck_nolock", 32'(locked), 32'd0);
        check("stuck_nolock_cyc", 32'(locked_cycles - lc0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
